// File: rtl/universal_shift_reg.sv
// WIDTH-bit storage/shift element: hold, load, logical/arithmetic/rotate shifts,
// clear and clock enable, with a saturating count of shifts since the last load.
module universal_shift_reg #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] d,
    input  logic             si,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_bar,
    output logic             so,
    output logic             zero,
    output logic [CNT_W-1:0] cnt,
    output logic             cnt_full
);

    typedef enum logic [2:0] {
        OP_HOLD = 3'b000,
        OP_LOAD = 3'b001,
        OP_SHL  = 3'b010,
        OP_SHR  = 3'b011,
        OP_ROTL = 3'b100,
        OP_ROTR = 3'b101,
        OP_ASR  = 3'b110,
        OP_CLR  = 3'b111
    } op_e;

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] WIDTH_CNT = CNT_W'(WIDTH);

    // Catch illegal parameter combinations at elaboration time.
    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
        $error("universal_shift_reg: WIDTH must be in 2..32");
    end
    if ((64'd1 << CNT_W) <= 64'(WIDTH)) begin : g_bad_cnt_w
        $error("universal_shift_reg: 2**CNT_W must exceed WIDTH");
    end

    op_e              op_sel;
    logic [WIDTH-1:0] q_reg, q_next;
    logic             so_reg, so_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             is_shift;
    logic             cnt_clear;

    assign op_sel = op_e'(op);

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        q_next    = q_reg;
        so_next   = so_reg;
        is_shift  = 1'b0;
        cnt_clear = 1'b0;
        unique case (op_sel)
            OP_HOLD: ;
            OP_LOAD: begin
                q_next    = d;
                so_next   = 1'b0;
                cnt_clear = 1'b1;
            end
            OP_SHL: begin
                q_next   = {q_reg[WIDTH-2:0], si};
                so_next  = q_reg[WIDTH-1];
                is_shift = 1'b1;
            end
            OP_SHR: begin
                q_next   = {si, q_reg[WIDTH-1:1]};
                so_next  = q_reg[0];
                is_shift = 1'b1;
            end
            OP_ROTL: begin
                q_next   = {q_reg[WIDTH-2:0], q_reg[WIDTH-1]};
                so_next  = q_reg[WIDTH-1];
                is_shift = 1'b1;
            end
            OP_ROTR: begin
                q_next   = {q_reg[0], q_reg[WIDTH-1:1]};
                so_next  = q_reg[0];
                is_shift = 1'b1;
            end
            OP_ASR: begin
                q_next   = {q_reg[WIDTH-1], q_reg[WIDTH-1:1]};
                so_next  = q_reg[0];
                is_shift = 1'b1;
            end
            OP_CLR: begin
                q_next    = '0;
                so_next   = 1'b0;
                cnt_clear = 1'b1;
            end
            default: ;
        endcase
    end

    // The counter sticks at its maximum rather than wrapping back to small values.
    always_comb begin
        cnt_next = cnt_reg;
        if (cnt_clear) begin
            cnt_next = '0;
        end else if (is_shift && cnt_reg != CNT_MAX) begin
            cnt_next = cnt_reg + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            q_reg   <= '0;
            so_reg  <= 1'b0;
            cnt_reg <= '0;
        end else if (en) begin
            q_reg   <= q_next;
            so_reg  <= so_next;
            cnt_reg <= cnt_next;
        end
    end

    assign q        = q_reg;
    assign q_bar    = ~q_reg;
    assign zero     = (q_reg == '0);
    assign so       = so_reg;
    assign cnt      = cnt_reg;
    assign cnt_full = (cnt_reg >= WIDTH_CNT);

endmodule

// File: tb/tb_universal_shift_reg.sv
// Directed bench for universal_shift_reg: a reference model pushes expected state
// into a scoreboard at each drive, popped and compared one edge later.
module tb_universal_shift_reg;

    localparam int WIDTH = 8;
    localparam int CNT_W = 5;

    logic             clk;
    logic             reset;
    logic             en;
    logic [2:0]       op;
    logic [WIDTH-1:0] d;
    logic             si;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] q_bar;
    logic             so;
    logic             zero;
    logic [CNT_W-1:0] cnt;
    logic             cnt_full;

    localparam logic [2:0] HOLD = 3'b000, LOAD = 3'b001, SHL = 3'b010, SHR = 3'b011,
                           ROTL = 3'b100, ROTR = 3'b101, ASR = 3'b110, CLR = 3'b111;

    // {q, q_bar, zero, so, cnt, cnt_full}
    typedef logic [23:0] snap_t;

    snap_t            sb_q[$];
    logic [WIDTH-1:0] mq;
    logic             mso;
    logic [CNT_W-1:0] mcnt;
    int               errors = 0;
    int               checks = 0;

    universal_shift_reg #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .en(en), .op(op), .d(d), .si(si),
        .q(q), .q_bar(q_bar), .so(so), .zero(zero), .cnt(cnt), .cnt_full(cnt_full)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic snap_t model_snap();
        return {mq, ~mq, (mq == 8'h00), mso, mcnt, (mcnt >= 5'd8)};
    endfunction

    // Arithmetic-style reference, deliberately unlike the RTL concatenations.
    task automatic model_step(input logic r, input logic e, input logic [2:0] o,
                              input logic [7:0] dd, input logic s);
        logic shifted;
        shifted = 1'b0;
        if (r) begin
            mq = 8'h00; mso = 1'b0; mcnt = 5'd0;
        end else if (e) begin
            case (o)
                LOAD: begin mq = dd; mso = 1'b0; mcnt = 5'd0; end
                CLR:  begin mq = 8'h00; mso = 1'b0; mcnt = 5'd0; end
                SHL:  begin mso = mq[7]; mq = (mq << 1) | {7'd0, s}; shifted = 1'b1; end
                SHR:  begin mso = mq[0]; mq = (mq >> 1) | ({7'd0, s} << 7); shifted = 1'b1; end
                ROTL: begin mso = mq[7]; mq = (mq << 1) | (mq >> 7); shifted = 1'b1; end
                ROTR: begin mso = mq[0]; mq = (mq >> 1) | (mq << 7); shifted = 1'b1; end
                ASR:  begin mso = mq[0]; mq = 8'($signed(mq) >>> 1); shifted = 1'b1; end
                default: ;
            endcase
            if (shifted && mcnt != 5'd31) mcnt = mcnt + 5'd1;
        end
    endtask

    task automatic compare(input string tag);
        snap_t exp;
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s: observed=empty scoreboard expected=entry", tag);
        end else begin
            exp = sb_q.pop_front();
            chk(tag, {8'd0, q, q_bar, zero, so, cnt, cnt_full}, {8'd0, exp});
        end
    endtask

    // Drive one cycle, record expectation, clock, compare #1 after the edge.
    task automatic step(input string tag, input logic r, input logic e, input logic [2:0] o,
                        input logic [7:0] dd, input logic s);
        reset = r; en = e; op = o; d = dd; si = s;
        model_step(r, e, o, dd, s);
        sb_q.push_back(model_snap());
        @(posedge clk);
        #1;
        compare(tag);
    endtask

    initial begin
        reset = 1'b1; en = 1'b1; op = LOAD; d = 8'hA5; si = 1'b0;
        mq = 8'h00; mso = 1'b0; mcnt = 5'd0;

        // Reset beats a simultaneous LOAD, then LOAD takes effect.
        step("reset_over_load", 1, 1, LOAD, 8'hA5, 0);
        chk("reset_q", {24'd0, q}, 32'h00);
        chk("reset_qbar", {24'd0, q_bar}, 32'hFF);
        step("load_a5", 0, 1, LOAD, 8'hA5, 0);
        chk("load_qbar", {24'd0, q_bar}, 32'h5A);

        // Logical shift left with si=1.
        step("load_96", 0, 1, LOAD, 8'b1001_0110, 0);
        for (int i = 0; i < 3; i++) step("shl", 0, 1, SHL, 8'h00, 1);
        chk("shl_q", {24'd0, q}, 32'hB7);
        chk("shl_so_cnt_full", {26'd0, so, cnt, cnt_full}, {26'd0, 1'b0, 5'd3, 1'b0});

        // Rotate round trip then counter saturation.
        step("load_c3", 0, 1, LOAD, 8'hC3, 0);
        for (int i = 0; i < 8; i++) step("rotr", 0, 1, ROTR, 8'h00, 0);
        chk("rotr_trip", {16'd0, q, 2'd0, cnt, cnt_full}, {16'd0, 8'hC3, 2'd0, 5'd8, 1'b1});
        for (int i = 0; i < 26; i++) step("rotr_sat", 0, 1, ROTR, 8'h00, 0);
        chk("cnt_sat", {27'd0, cnt}, 32'd31);
        step("rotl_sat", 0, 1, ROTL, 8'h00, 1);
        step("shr_mix", 0, 1, SHR, 8'h00, 1);

        // Arithmetic shift right, sign fill and si ignored.
        step("load_80", 0, 1, LOAD, 8'h80, 0);
        for (int i = 0; i < 3; i++) step("asr_neg", 0, 1, ASR, 8'h00, 0);
        chk("asr_neg_q", {23'd0, q, so}, {23'd0, 8'hF0, 1'b0});
        step("load_7f", 0, 1, LOAD, 8'h7F, 0);
        step("asr_pos", 0, 1, ASR, 8'h00, 1);
        chk("asr_pos_q", {23'd0, q, so}, {23'd0, 8'h3F, 1'b1});

        // Enable gating.
        step("load_55", 0, 1, LOAD, 8'h55, 0);
        for (int i = 0; i < 4; i++) step("gated", 0, 0, SHL, 8'hFF, 1);
        step("ungated_shl", 0, 1, SHL, 8'h00, 0);
        chk("gate_q_cnt", {19'd0, q, cnt}, {19'd0, 8'hAA, 5'd1});
        step("gated_hold", 0, 0, LOAD, 8'h12, 0);
        step("hold_op", 0, 1, HOLD, 8'h34, 1);

        // Clear mid-stream, then reset pulse between edges, then held reset.
        step("load_e7", 0, 1, LOAD, 8'hE7, 0);
        for (int i = 0; i < 3; i++) step("shr_stream", 0, 1, SHR, 8'h00, 1);
        step("clr", 0, 1, CLR, 8'h00, 1);
        chk("clr_zero_cnt", {26'd0, zero, cnt}, {26'd0, 1'b1, 5'd0});
        step("load_e7b", 0, 1, LOAD, 8'hE7, 0);
        step("shr_restart", 0, 1, SHR, 8'h00, 0);

        reset = 1'b0; en = 1'b1; op = SHR; d = 8'h00; si = 1'b1;
        model_step(0, 1, SHR, 8'h00, 1);
        sb_q.push_back(model_snap());
        #2 reset = 1'b1;
        #2 reset = 1'b0;
        @(posedge clk);
        #1;
        compare("reset_glitch");

        step("reset_held", 1, 1, SHR, 8'h00, 1);
        chk("reset_held_q", {23'd0, q, zero}, {23'd0, 8'h00, 1'b1});
        step("post_reset_load", 0, 1, LOAD, 8'h3C, 0);
        step("post_reset_rotl", 0, 1, ROTL, 8'h00, 0);

        chk("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/universal_shift_reg.md
# universal_shift_reg

Parametrised WIDTH-bit register with q/q_bar outputs, extending the single-bit D flip-flop into a multi-mode storage and shift element. Supports hold, parallel load, logical/arithmetic/rotate shifts, synchronous clear, and a clock enable. Tracks shifts performed since the last load or clear. Serves as the storage and serialisation primitive for the upcoming counter and serial-link labs.

## Interface
- WIDTH, 8, register width in bits; legal range 2..32
- CNT_W, 5, width of the shift counter; must satisfy 2^CNT_W > WIDTH

- clk  input  1  rising-edge clock; sole clock of the block
- reset  input  1  synchronous, active-high reset, sampled on rising clk
- en  input  1  clock enable; 0 = all state holds
- op  input  3  operation select, see Operation
- d  input  WIDTH  parallel load data
- si  input  1  serial input for logical shifts
- q  output  WIDTH  register contents
- q_bar  output  WIDTH  bitwise complement of q
- so  output  1  bit shifted out by the most recent shift/rotate
- zero  output  1  1 when q == 0
- cnt  output  CNT_W  shifts/rotates since last load, clear or reset; saturates
- cnt_full  output  1  1 when cnt == WIDTH or higher

## Operation
- Priority at each rising clk: reset > en == 0 > op.
- reset = 1: q = 0, q_bar = all ones, so = 0, cnt = 0. en and op are ignored.
- en = 0: q, so and cnt hold.
- op decode when en = 1:
  - 000 HOLD: q holds; so and cnt hold.
  - 001 LOAD: q <= d; cnt <= 0; so <= 0.
  - 010 SHL: q <= {q[WIDTH-2:0], si}; so <= q[WIDTH-1].
  - 011 SHR: q <= {si, q[WIDTH-1:1]}; so <= q[0].
  - 100 ROTL: q <= {q[WIDTH-2:0], q[WIDTH-1]}; so <= q[WIDTH-1].
  - 101 ROTR: q <= {q[0], q[WIDTH-1:1]}; so <= q[0].
  - 110 ASR: q <= {q[WIDTH-1], q[WIDTH-1:1]}; so <= q[0]; si is ignored.
  - 111 CLR: q <= 0; cnt <= 0; so <= 0.
- cnt:
  - Increments by 1 on every executed shift/rotate (ops 010–110).
  - Saturates at 2^CNT_W − 1 and does not wrap.
  - cnt_full = (cnt >= WIDTH). It signals that the original load data has been fully shifted out (SHL/SHR/ASR) or fully rotated back (ROTL/ROTR).
- Outputs:
  - q_bar and zero are combinational from the q register only, never from d or op.
  - cnt_full is combinational from cnt.
- Unused/illegal states: none. All 3-bit op codes are defined.

## Timing
- Every registered output changes only on a rising clk edge. Latency from input sample to q/so/cnt is 1 cycle.
- q_bar, zero and cnt_full settle in the same cycle as q/cnt. There is no extra register stage.
- Reset is synchronous: asserting reset between edges has no effect until the next rising edge.
- If reset is asserted in the same cycle as any op, the reset values win. An op issued mid-sequence is discarded, and cnt returns to 0.
- en may toggle every cycle. A gated cycle never advances cnt.
- Back-to-back ops are allowed every cycle, with no bubbles. A LOAD immediately after a shift discards the shifted state; cnt reads 0 in the following cycle.
- d and si need only be valid around the sampling edge.
- There are no combinational paths from inputs to outputs.

## Test plan
- Reset: drive op=001, d=8'hA5, en=1, reset=1 for one edge -> q=8'h00, q_bar=8'hFF, zero=1, cnt=0, so=0. Then release reset with LOAD still driven -> q=8'hA5, q_bar=8'h5A, zero=0.
- Logical shift: LOAD 8'b1001_0110, then SHL with si=1 for 3 cycles -> q=8'b1011_0111, so=0 after the last shift (bits shifted out were 1, 0, 0), cnt=3, cnt_full=0.
- Rotate round trip: LOAD 8'hC3, then ROTR for 8 cycles -> q=8'hC3, cnt=8, cnt_full=1. Continue to 31+ shifts -> cnt stays at 31.
- Arithmetic shift: LOAD 8'h80, then ASR ×3 with si=0 -> q=8'hF0, so=0. LOAD 8'h7F, then ASR ×1 -> q=8'h3F, so=1.
- Enable gating: LOAD 8'h55; hold en=0 while op=010 for 4 cycles -> q stays 8'h55 and cnt stays 0. Set en=1 for 1 cycle -> q=8'hAA (si=0), cnt=1.
- Clear and sync reset mid-sequence: during an SHR stream, assert CLR -> q=0, zero=1, cnt=0. Restart the SHR stream and pulse reset between edges only (deasserted before the next rising edge) -> no effect. Hold reset across an edge -> q=0 next cycle.
